instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: LENGTH, default 16, instruction width; ADDR_WIDTH, default 8, word-address width; RESET_PC, default 0, first fetch address.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port imem_req, output, 1: read request to instruction memory.
REQ-005 Port imem_addr, output, ADDR_WIDTH: word address of the current request.
REQ-006 Port imem_rdata, input, LENGTH: returned instruction word.
REQ-007 Port imem_valid, input, 1: imem_rdata valid; meaningful only while imem_req=1.
REQ-008 Port stall, input, 1: the decode stage cannot accept a new word this cycle.
REQ-009 Port redirect, input, 1: branch/jump taken; flush and refetch.
REQ-010 Port redirect_pc, input, ADDR_WIDTH: target address, sampled when redirect=1.
REQ-011 Port instr, output, LENGTH: fetched word driven to the decoder.
REQ-012 Port instr_pc, output, ADDR_WIDTH: address of instr.
REQ-013 Port instr_valid, output, 1: instr/instr_pc hold a live word.
REQ-014 Port halted, output, 1: fetch stopped on HLT.

Function
REQ-015 FSM states SHALL be FETCH and HALT; reset enters FETCH.
REQ-016 imem_req SHALL be 1 iff state=FETCH and (instr_valid=0 or stall=0) and redirect=0.
REQ-017 imem_addr SHALL equal the internal pc register and stay stable while imem_req=1 and imem_valid=0.
REQ-018 A word SHALL be accepted in a cycle with imem_req=1 and imem_valid=1; next edge: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-019 pc+1 SHALL wrap modulo 2^ADDR_WIDTH (all-ones -> 0).
REQ-020 instr_valid=1 with stall=1 SHALL hold instr, instr_pc, instr_valid, pc unchanged; no request issued.
REQ-021 instr_valid=1, stall=0, no acceptance that cycle SHALL clear instr_valid at next edge.
REQ-022 stall=0 plus acceptance in the same cycle SHALL replace the output word with no bubble (one word per cycle when imem_valid is held high).
REQ-023 Dropping imem_req without imem_valid SHALL abandon the request; memory reads are side-effect free.
REQ-024 redirect=1 SHALL have priority over acceptance and stall: next edge pc<=redirect_pc, instr_valid<=0; any imem_valid that cycle discarded.
REQ-025 Fetch latency: redirect at cycle N -> imem_addr=redirect_pc at N+1 -> instr_valid at earliest N+2.
REQ-026 In HALT, imem_req SHALL be 0, pc frozen, redirect ignored; only reset exits HALT.

Reset
REQ-027 rst_n=0 SHALL immediately force: pc=RESET_PC, state=FETCH, instr=0, instr_pc=0, instr_valid=0, halted=0, hence imem_req=0 during reset.
REQ-028 First request SHALL issue in the first cycle after rst_n deasserts, imem_addr=RESET_PC.
REQ-029 Reset asserted mid-request or mid-stall SHALL discard all in-flight and held words.

Configuration
REQ-030 Macro HLT_DETECT_EN defined: an accepted word with instr[15:11]=5'b11100 and instr[1:0]!=2'b00 SHALL move state to HALT at that edge; halted=1 from that edge; the HLT word stays on instr with instr_valid=1 until consumed (stall=0), then instr_valid clears.
REQ-031 A redirect in the same cycle as HLT acceptance SHALL win (no halt, HLT discarded).
REQ-032 Macro HLT_DETECT_EN undefined: halted SHALL be tied 0, HALT unreachable, HLT words fetched like any other.

Verification
REQ-033 Reset release, imem_valid=1 always, stall=0, ADDR_WIDTH=8 -> instr_pc sequence 0,1,2,... one per cycle, instr_valid continuous from 2nd cycle.
REQ-034 stall=1 for 3 cycles while instr=16'h0A05 at pc 4 -> instr/instr_pc held, imem_req=0 for 3 cycles, next word pc 5.
REQ-035 redirect=1, redirect_pc=8'h40 while imem_valid=1 -> returned word dropped, instr_valid=0 next cycle, imem_addr=8'h40.
REQ-036 pc=8'hFF accepted -> next imem_addr=8'h00.
REQ-037 HLT_DETECT_EN, word 16'hE001 at pc 3 -> halted=1, imem_req=0 thereafter, later redirect ignored; without macro fetch continues at pc 4.
REQ-038 rst_n low mid-stall with instr_valid=1 -> instr_valid=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-word instruction fetch stage.
// Holds a program counter and issues word reads to instruction memory.
// Accepted words are presented to decode with their address. A stall
// holds the presented word, and a redirect flushes it and restarts the
// fetch at a new address.
// Optional feature: define HLT_DETECT_EN to stop fetching on an HLT word
// (instr[15:11]=5'b11100, instr[1:0]!=0). Only reset leaves the halted state.
module instr_fetch #(
  parameter int unsigned            LENGTH     = 16,
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [LENGTH-1:0]     imem_rdata,
  input  logic                  imem_valid,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [LENGTH-1:0]     instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  halted
);

  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [LENGTH-1:0]     instr_reg;
  logic [ADDR_WIDTH-1:0] instr_pc_reg;
  logic                  instr_valid_reg;
  logic                  accept;
  logic                  hlt_hit;

  // A word is taken whenever a request is outstanding and memory answers it.
  assign accept = imem_req & imem_valid;

`ifdef HLT_DETECT_EN
  assign hlt_hit = accept && (imem_rdata[15:11] == 5'b11100) && (imem_rdata[1:0] != 2'b00);
  assign halted  = (state_reg == HALT);
`else
  assign hlt_hit = 1'b0;
  assign halted  = 1'b0;
`endif

  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;

  // State register: reset always returns to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and request. Reset is also gated in here so that no request
  // leaves the block while rst_n is low.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    if (rst_n && (state_reg == FETCH) && (!instr_valid_reg || !stall) && !redirect) begin
      imem_req = 1'b1;
    end
    if ((state_reg == FETCH) && hlt_hit) begin
      state_next = HALT;
    end
  end

  // Datapath. In HALT a redirect is ignored. No request is issued there,
  // so the only activity is draining the held word once decode takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
    end else if ((state_reg == FETCH) && redirect) begin
      pc_reg          <= redirect_pc;
      instr_valid_reg <= 1'b0;
    end else if (accept) begin
      instr_reg       <= imem_rdata;
      instr_pc_reg    <= pc_reg;
      instr_valid_reg <= 1'b1;
      pc_reg          <= pc_reg + 1'b1;
    end else if (instr_valid_reg && !stall) begin
      instr_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven directed bench for instr_fetch (8-bit addresses).
// The memory model returns {8'h5A, addr}, 16'h0A05 at address 4, and
// optionally an HLT word (16'hE001) at address 3.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        plant_hlt;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch #(.LENGTH(16), .ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = (plant_hlt && imem_addr == 8'h03) ? 16'hE001 :
                      (imem_addr == 8'h04) ? 16'h0A05 : {8'h5A, imem_addr};

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [7:0]  rpc;
    logic        ivalid;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic        exp_valid;
    logic [7:0]  exp_ipc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Stall, valid drop, redirect and wrap sequence after reset release.
    vecs[0]  = '{0,0,8'h00,1, 1,8'h00,0,8'h00,16'h0000};
    vecs[1]  = '{0,0,8'h00,1, 1,8'h01,1,8'h00,16'h5A00};
    vecs[2]  = '{0,0,8'h00,1, 1,8'h02,1,8'h01,16'h5A01};
    vecs[3]  = '{0,0,8'h00,1, 1,8'h03,1,8'h02,16'h5A02};
    vecs[4]  = '{0,0,8'h00,1, 1,8'h04,1,8'h03,16'h5A03};
    vecs[5]  = '{1,0,8'h00,1, 0,8'h05,1,8'h04,16'h0A05};
    vecs[6]  = '{1,0,8'h00,1, 0,8'h05,1,8'h04,16'h0A05};
    vecs[7]  = '{1,0,8'h00,1, 0,8'h05,1,8'h04,16'h0A05};
    vecs[8]  = '{0,0,8'h00,1, 1,8'h05,1,8'h04,16'h0A05};
    vecs[9]  = '{0,0,8'h00,0, 1,8'h06,1,8'h05,16'h5A05};
    vecs[10] = '{0,0,8'h00,1, 1,8'h06,0,8'h05,16'h5A05};
    vecs[11] = '{0,1,8'h40,1, 0,8'h07,1,8'h06,16'h5A06};
    vecs[12] = '{0,0,8'h00,1, 1,8'h40,0,8'h06,16'h5A06};
    vecs[13] = '{0,1,8'hFE,1, 0,8'h41,1,8'h40,16'h5A40};
    vecs[14] = '{0,0,8'h00,1, 1,8'hFE,0,8'h40,16'h5A40};
    vecs[15] = '{0,0,8'h00,1, 1,8'hFF,1,8'hFE,16'h5AFE};
    vecs[16] = '{1,0,8'h00,1, 0,8'h00,1,8'hFF,16'h5AFF};

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    imem_valid = 1'b1; plant_hlt = 1'b0;

    // Reset state while rst_n is held low.
    @(negedge clk); #1;
    check("rst_req",    {31'b0, imem_req},    32'd0);
    check("rst_valid",  {31'b0, instr_valid}, 32'd0);
    check("rst_ipc",    {24'b0, instr_pc},    32'd0);
    check("rst_instr",  {16'b0, instr},       32'd0);
    check("rst_halted", {31'b0, halted},      32'd0);
    check("rst_addr",   {24'b0, imem_addr},   32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      imem_valid  = vecs[i].ivalid;
      #1;
      $display("vec %0d: req=%b addr=%h valid=%b ipc=%h instr=%h", i, imem_req, imem_addr, instr_valid, instr_pc, instr);
      check($sformatf("v%0d_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i),   {24'b0, imem_addr},   {24'b0, vecs[i].exp_addr});
      check($sformatf("v%0d_valid", i),  {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("v%0d_ipc", i),    {24'b0, instr_pc},    {24'b0, vecs[i].exp_ipc});
      check($sformatf("v%0d_instr", i),  {16'b0, instr},       {16'b0, vecs[i].exp_instr});
      check($sformatf("v%0d_halted", i), {31'b0, halted},      32'd0);
      next_cycle();
    end

    // Reset asserted while a stalled word is held.
    #1;
    check("stallhold_valid", {31'b0, instr_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    $display("midstall reset: valid=%b req=%b ipc=%h", instr_valid, imem_req, instr_pc);
    check("midrst_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_req",   {31'b0, imem_req},    32'd0);
    check("midrst_ipc",   {24'b0, instr_pc},    32'd0);
    check("midrst_instr", {16'b0, instr},       32'd0);
    next_cycle();
    rst_n = 1'b1; stall = 1'b0;
    #1;
    $display("restart: req=%b addr=%h", imem_req, imem_addr);
    check("restart_req",  {31'b0, imem_req},  32'd1);
    check("restart_addr", {24'b0, imem_addr}, 32'd0);

    // HLT word at address 3.
    rst_n = 1'b0; plant_hlt = 1'b1; imem_valid = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    #1;
    $display("hlt accepted: ipc=%h instr=%h halted=%b req=%b", instr_pc, instr, halted, imem_req);
    check("hlt_ipc",   {24'b0, instr_pc},    32'h03);
    check("hlt_instr", {16'b0, instr},       32'hE001);
    check("hlt_valid", {31'b0, instr_valid}, 32'd1);
`ifdef HLT_DETECT_EN
    check("hlt_halted", {31'b0, halted},   32'd1);
    check("hlt_req",    {31'b0, imem_req}, 32'd0);
    stall = 1'b1;
    next_cycle(); #1;
    check("hlt_hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hlt_hold_ipc",   {24'b0, instr_pc},    32'h03);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 8'h20;
    next_cycle();
    redirect = 1'b0; #1;
    $display("hlt after redirect: valid=%b halted=%b req=%b addr=%h", instr_valid, halted, imem_req, imem_addr);
    check("hlt_drain_valid", {31'b0, instr_valid}, 32'd0);
    check("hlt_stay",        {31'b0, halted},      32'd1);
    check("hlt_noreq",       {31'b0, imem_req},    32'd0);
    check("hlt_pc_frozen",   {24'b0, imem_addr},   32'h04);
`else
    check("hlt_halted", {31'b0, halted},    32'd0);
    check("hlt_req",    {31'b0, imem_req},  32'd1);
    check("hlt_addr",   {24'b0, imem_addr}, 32'h04);
    next_cycle(); #1;
    $display("no hlt: ipc=%h instr=%h", instr_pc, instr);
    check("nohlt_ipc",   {24'b0, instr_pc}, 32'h04);
    check("nohlt_instr", {16'b0, instr},    32'h0A05);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
